// File: rtl/mem_bus_arbiter.sv
// Memory-port arbiter for icache/dcache line refills and dcache writebacks.
// Define ARB_RR_EN for round-robin between the two read requesters.
module mem_bus_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int OFFSET_W   = $clog2(LINE_WORDS) + 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rreq,
  input  logic [31:0] i_raddr,
  output logic        i_rgnt,
  output logic        i_rvalid,
  output logic        i_rlast,
  output logic [31:0] i_rdata,
  input  logic        d_rreq,
  input  logic [31:0] d_raddr,
  output logic        d_rgnt,
  output logic        d_rvalid,
  output logic        d_rlast,
  output logic [31:0] d_rdata,
  input  logic        d_wreq,
  input  logic [31:0] d_waddr,
  input  logic [31:0] d_wdata,
  output logic        d_wnext,
  output logic        d_wdone,
  output logic        mem_rreq,
  output logic [31:0] mem_raddr,
  output logic [7:0]  mem_rlen,
  input  logic        mem_rrdy,
  input  logic        mem_rvalid,
  input  logic        mem_rlast,
  input  logic [31:0] mem_rdata,
  output logic        mem_wreq,
  output logic [31:0] mem_waddr,
  output logic [7:0]  mem_wlen,
  input  logic        mem_wrdy,
  output logic        mem_wvalid,
  output logic        mem_wlast,
  output logic [31:0] mem_wdata,
  input  logic        mem_wready,
  input  logic        mem_bvalid
);

  localparam int CW = $clog2(LINE_WORDS);
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);
  localparam logic [7:0] BLEN = 8'(LINE_WORDS - 1);
  localparam logic [31:0] AMASK =
    ~((32'd1 << OFFSET_W) - 32'd1);

  typedef enum logic [2:0] {
    IDLE, I_RA, I_RD, D_RA, D_RD, D_WA, D_WD, D_WB
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   addr_q;
  logic          pick_d;

`ifdef ARB_RR_EN
  // last_d=1 means dcache won the previous read, so icache is favoured
  logic last_d;

  assign pick_d = d_rreq & (~i_rreq | ~last_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d <= 1'b1;
    end else if (state == IDLE && !d_wreq) begin
      if (pick_d)
        last_d <= 1'b1;
      else if (i_rreq)
        last_d <= 1'b0;
    end
  end
`else
  assign pick_d = d_rreq;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_wreq) begin
            state  <= D_WA;
            addr_q <= d_waddr & AMASK;
            cnt    <= '0;
          end else if (pick_d) begin
            state  <= D_RA;
            addr_q <= d_raddr & AMASK;
          end else if (i_rreq) begin
            state  <= I_RA;
            addr_q <= i_raddr & AMASK;
          end
        end
        I_RA: if (mem_rrdy) state <= I_RD;
        D_RA: if (mem_rrdy) state <= D_RD;
        I_RD, D_RD: begin
          if (mem_rvalid && mem_rlast)
            state <= IDLE;
        end
        D_WA: if (mem_wrdy) state <= D_WD;
        D_WD: begin
          if (mem_wready) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST)
              state <= D_WB;
          end
        end
        D_WB: if (mem_bvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic in_ird, in_drd, in_wd;

  assign in_ird = (state == I_RD);
  assign in_drd = (state == D_RD);
  assign in_wd  = (state == D_WD);

  assign mem_rreq  = (state == I_RA) | (state == D_RA);
  assign mem_raddr = mem_rreq ? addr_q : '0;
  assign mem_rlen  = mem_rreq ? BLEN : '0;
  assign i_rgnt    = (state == I_RA) & mem_rrdy;
  assign d_rgnt    = (state == D_RA) & mem_rrdy;

  assign i_rvalid = in_ird & mem_rvalid;
  assign i_rlast  = in_ird & mem_rlast;
  assign i_rdata  = in_ird ? mem_rdata : '0;
  assign d_rvalid = in_drd & mem_rvalid;
  assign d_rlast  = in_drd & mem_rlast;
  assign d_rdata  = in_drd ? mem_rdata : '0;

  assign mem_wreq   = (state == D_WA);
  assign mem_waddr  = mem_wreq ? addr_q : '0;
  assign mem_wlen   = mem_wreq ? BLEN : '0;
  assign mem_wvalid = in_wd;
  assign mem_wlast  = in_wd & (cnt == LAST);
  assign mem_wdata  = in_wd ? d_wdata : '0;
  assign d_wnext    = in_wd & mem_wready;
  assign d_wdone    = (state == D_WB) & mem_bvalid;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: reads, writeback ordering,
// arbitration order, throttled write beats, mid-burst reset, stray beats.
module tb_mem_bus_arbiter;

  localparam int LW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_rreq = 1'b0;
  logic [31:0] i_raddr = '0;
  logic        i_rgnt, i_rvalid, i_rlast;
  logic [31:0] i_rdata;
  logic        d_rreq = 1'b0;
  logic [31:0] d_raddr = '0;
  logic        d_rgnt, d_rvalid, d_rlast;
  logic [31:0] d_rdata;
  logic        d_wreq = 1'b0;
  logic [31:0] d_waddr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_wnext, d_wdone;
  logic        mem_rreq;
  logic [31:0] mem_raddr;
  logic [7:0]  mem_rlen;
  logic        mem_rrdy = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic        mem_rlast = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_wreq;
  logic [31:0] mem_waddr;
  logic [7:0]  mem_wlen;
  logic        mem_wrdy = 1'b0;
  logic        mem_wvalid, mem_wlast;
  logic [31:0] mem_wdata;
  logic        mem_wready = 1'b0;
  logic        mem_bvalid = 1'b0;

  int vecs = 0;
  int errs = 0;

  mem_bus_arbiter #(.LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst),
    .i_rreq(i_rreq), .i_raddr(i_raddr), .i_rgnt(i_rgnt),
    .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_rdata(i_rdata),
    .d_rreq(d_rreq), .d_raddr(d_raddr), .d_rgnt(d_rgnt),
    .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_rdata(d_rdata),
    .d_wreq(d_wreq), .d_waddr(d_waddr), .d_wdata(d_wdata),
    .d_wnext(d_wnext), .d_wdone(d_wdone),
    .mem_rreq(mem_rreq), .mem_raddr(mem_raddr),
    .mem_rlen(mem_rlen), .mem_rrdy(mem_rrdy),
    .mem_rvalid(mem_rvalid), .mem_rlast(mem_rlast),
    .mem_rdata(mem_rdata),
    .mem_wreq(mem_wreq), .mem_waddr(mem_waddr),
    .mem_wlen(mem_wlen), .mem_wrdy(mem_wrdy),
    .mem_wvalid(mem_wvalid), .mem_wlast(mem_wlast),
    .mem_wdata(mem_wdata), .mem_wready(mem_wready),
    .mem_bvalid(mem_bvalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Waits for a read address phase, grants it, streams LW beats.
  // abort_at >= 0 pulses rst in place of that beat.
  task automatic do_read(input bit          exp_d,
                         input logic [31:0] exp_addr,
                         input logic [31:0] base,
                         input int          rdy_wait,
                         input int          abort_at);
    int n = 0;
    logic [1:0] side;
    side = exp_d ? 2'b01 : 2'b10;
    while (!mem_rreq && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    chk("rreq_seen", 32'(mem_rreq), 1);
    chk("raddr", mem_raddr, exp_addr);
    chk("rlen", 32'(mem_rlen), LW - 1);
    chk("wreq_off", 32'(mem_wreq), 0);
    for (int w = 0; w < rdy_wait; w++) begin
      chk("rgnt_wait", 32'({i_rgnt, d_rgnt}), 0);
      @(negedge clk); #1;
      chk("rreq_hold", 32'(mem_rreq), 1);
    end
    mem_rrdy = 1'b1;
    #1;
    chk("rgnt", 32'({i_rgnt, d_rgnt}), 32'(side));
    if (exp_d) d_rreq = 1'b0;
    else       i_rreq = 1'b0;
    @(negedge clk);
    mem_rrdy = 1'b0;
    for (int b = 0; b < LW; b++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = base + 32'(b);
      mem_rlast  = (b == LW - 1);
      if (b == abort_at) begin
        rst = 1'b1;
        #1;
        chk("rst_mid_ctl",
            32'({i_rvalid, i_rlast, d_rvalid, mem_rreq, i_rgnt}), 0);
        chk("rst_mid_dat", i_rdata | d_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
        return;
      end
      #1;
      if (b == 0) chk("rgnt_pulse", 32'({i_rgnt, d_rgnt}), 0);
      chk("rvalid", 32'({i_rvalid, d_rvalid}), 32'(side));
      chk("rdata", exp_d ? d_rdata : i_rdata, base + 32'(b));
      chk("rdata_other", exp_d ? i_rdata : d_rdata, 0);
      chk("rlast", 32'({i_rlast, d_rlast}),
          (b == LW - 1) ? 32'(side) : 0);
      @(negedge clk);
    end
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
    #1;
    chk("rd_end_idle", 32'(mem_rreq), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k, n;
    bit  tog;
    #1;
    chk("rst_ctl", 32'({mem_rreq, mem_wreq, mem_wvalid, mem_wlast,
                        i_rgnt, d_rgnt, i_rvalid, d_rvalid,
                        d_wnext, d_wdone}), 0);
    chk("rst_addr", mem_raddr | mem_waddr, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // stray beat in IDLE
    mem_rvalid = 1'b1;
    mem_rlast  = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    #1;
    chk("stray_v", 32'({i_rvalid, d_rvalid, i_rlast, d_rlast}), 0);
    chk("stray_d", i_rdata | d_rdata, 0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rlast  = 1'b0;
    #1;
    chk("stray_idle", 32'({mem_rreq, mem_wreq}), 0);

    // icache refill, slow address ready
    @(negedge clk);
    i_rreq  = 1'b1;
    i_raddr = 32'h0000_1234;
    do_read(1'b0, 32'h0000_1230, 32'h48C, 2, -1);

    // writeback before refill of the same line
    @(negedge clk);
    d_wreq  = 1'b1;
    d_waddr = 32'h0000_2040;
    d_rreq  = 1'b1;
    d_raddr = 32'h0000_2040;
    n = 0;
    while (!mem_wreq && n < 10) begin
      @(negedge clk); #1;
      n++;
    end
    chk("wreq_seen", 32'(mem_wreq), 1);
    chk("waddr", mem_waddr, 32'h0000_2040);
    chk("wlen", 32'(mem_wlen), LW - 1);
    chk("wa_no_rreq", 32'(mem_rreq), 0);
    mem_wrdy = 1'b1;
    @(negedge clk);
    mem_wrdy = 1'b0;
    d_wreq   = 1'b0;
    k = 0;
    n = 0;
    tog = 1'b1;
    while (k < LW && n < 20) begin
      mem_wready = tog;
      d_wdata    = 32'hA0 + 32'(k);
      #1;
      chk("wvalid", 32'(mem_wvalid), 1);
      chk("wdata", mem_wdata, 32'hA0 + 32'(k));
      chk("wnext", 32'(d_wnext), 32'(tog));
      chk("wlast", 32'(mem_wlast), 32'(k == LW - 1));
      if (tog) k++;
      tog = !tog;
      n++;
      @(negedge clk);
    end
    mem_wready = 1'b0;
    chk("wbeats", k, LW);
    #1;
    chk("wb_wait", 32'({mem_wvalid, d_wdone, mem_rreq}), 0);
    @(negedge clk);
    mem_bvalid = 1'b1;
    #1;
    chk("wdone", 32'(d_wdone), 1);
    @(negedge clk);
    mem_bvalid = 1'b0;
    #1;
    chk("wb_idle", 32'({mem_rreq, mem_wreq, d_wdone}), 0);
    do_read(1'b1, 32'h0000_2040, 32'h100, 0, -1);

    // both read sides requesting together
    @(negedge clk);
    i_rreq  = 1'b1;
    i_raddr = 32'h0000_3008;
    d_rreq  = 1'b1;
    d_raddr = 32'h0000_400C;
`ifdef ARB_RR_EN
    do_read(1'b0, 32'h0000_3000, 32'h200, 0, -1);
    do_read(1'b1, 32'h0000_4000, 32'h300, 0, -1);
`else
    do_read(1'b1, 32'h0000_4000, 32'h300, 0, -1);
    do_read(1'b0, 32'h0000_3000, 32'h200, 0, -1);
`endif

    // reset after the second beat, then a clean refill
    @(negedge clk);
    i_rreq  = 1'b1;
    i_raddr = 32'h0000_5004;
    do_read(1'b0, 32'h0000_5000, 32'h500, 1, 2);
    #1;
    chk("post_rst_idle", 32'({mem_rreq, i_rvalid}), 0);
    i_rreq  = 1'b1;
    i_raddr = 32'h0000_6010;
    do_read(1'b0, 32'h0000_6010, 32'h600, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
